// File: rtl/dac_spi_pkg.sv
// -----------------------------------------------------------------------------
// dac_spi_pkg
// Shared constants, the framing FSM state type and the frame builder for the
// serial DAC streamer.
// -----------------------------------------------------------------------------
package dac_spi_pkg;

   localparam int         FRAME_BITS = 16;
   localparam logic [1:0] CTRL_BITS  = 2'b00;
   localparam logic [3:0] PAD_BITS   = 4'b0000;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Frame layout, MSB first: channel/command, control, DAC code, padding.
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0] sel,
                                                         input logic [7:0] code);
      return {sel, CTRL_BITS, code, PAD_BITS};
   endfunction

endpackage

// File: rtl/dac_spi_if.sv
// -----------------------------------------------------------------------------
// dac_spi_if
// Bundles the DAC code inputs and the 3-wire serial DAC pins.
//   serial_data [7:0] : DAC code
//   select_flag [1:0] : channel/command bits
//   sclk              : serial clock, idles high
//   sync              : frame enable, active low
//   dac_din           : serial data, MSB first
// master = the streamer (drives the pins), slave = code source / DAC side.
// -----------------------------------------------------------------------------
interface dac_spi_if;
   logic [7:0] serial_data;
   logic [1:0] select_flag;
   logic       sclk;
   logic       sync;
   logic       dac_din;

   modport master (
      input  serial_data,
      input  select_flag,
      output sclk,
      output sync,
      output dac_din
   );

   modport slave (
      output serial_data,
      output select_flag,
      input  sclk,
      input  sync,
      input  dac_din
   );
endinterface

// File: rtl/dac_spi_clkdiv.sv
// -----------------------------------------------------------------------------
// dac_spi_clkdiv
// Free-running divider that strobes o_half_tick once every DIV_HALF clocks.
//   i_clk       : system clock
//   i_rst       : synchronous active-high reset
//   o_half_tick : high while the divider sits at its last count; the edge
//                 that sees it high is a half-tick edge
// -----------------------------------------------------------------------------
module dac_spi_clkdiv #(
   parameter int DIV_HALF = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_half_tick
);

   // A 1-bit counter is kept for DIV_HALF=1; it simply never leaves zero.
   localparam int            DW       = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV_HALF - 1);

   logic [DW-1:0] r_div;

   // Divider: counts 0..DIV_HALF-1 and wraps.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_div <= '0;
      end else if (r_div == DIV_LAST) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + DW'(1);
      end
   end

   assign o_half_tick = (r_div == DIV_LAST);

endmodule

// File: rtl/dac_spi_top.sv
// -----------------------------------------------------------------------------
// dac_spi_top
// Streams 16-bit frames {select_flag, 2'b00, serial_data, 4'b0000} to a serial
// DAC, back to back, with IDLE_SCLKS sclk periods of sync high between frames.
//   clk_in : system clock
//   rst    : synchronous active-high reset (aborts any frame in flight)
//   dac    : dac_spi_if master (inputs sampled at frame start, pins driven)
// -----------------------------------------------------------------------------
module dac_spi_top
   import dac_spi_pkg::*;
#(
   parameter int DIV_HALF   = 2,
   parameter int IDLE_SCLKS = 2
) (
   input  logic      clk_in,
   input  logic      rst,
   dac_spi_if.master dac
);

   localparam int            IDLE_TICKS = 2 * IDLE_SCLKS;
   localparam int            IW         = (IDLE_TICKS > 1) ? $clog2(IDLE_TICKS) : 1;
   localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TICKS - 1);
   localparam int            BW         = $clog2(FRAME_BITS);
   localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

   logic                  w_tick;
   logic [FRAME_BITS-1:0] w_frame;

   state_t                r_state,    w_state;
   logic [IW-1:0]         r_idle_cnt, w_idle_cnt;
   logic [BW-1:0]         r_bit_cnt,  w_bit_cnt;
   // Remaining bits after the one currently on dac_din.
   logic [FRAME_BITS-2:0] r_shift,    w_shift;
   logic                  r_sclk,     w_sclk;
   logic                  r_sync,     w_sync;
   logic                  r_din,      w_din;

   dac_spi_clkdiv #(.DIV_HALF(DIV_HALF)) u_clkdiv (
      .i_clk       (clk_in),
      .i_rst       (rst),
      .o_half_tick (w_tick)
   );

   assign w_frame = build_frame(dac.select_flag, dac.serial_data);

   // State and output registers; everything changes only on half-tick edges.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_state    <= IDLE;
         r_idle_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_sclk     <= 1'b1;
         r_sync     <= 1'b1;
         r_din      <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_idle_cnt <= w_idle_cnt;
         r_bit_cnt  <= w_bit_cnt;
         r_shift    <= w_shift;
         r_sclk     <= w_sclk;
         r_sync     <= w_sync;
         r_din      <= w_din;
      end
   end

   // Next-state and next-output logic for the framing FSM.
   always_comb begin
      w_state    = r_state;
      w_idle_cnt = r_idle_cnt;
      w_bit_cnt  = r_bit_cnt;
      w_shift    = r_shift;
      w_sclk     = r_sclk;
      w_sync     = r_sync;
      w_din      = r_din;
      case (r_state)
         IDLE: begin
            if (w_tick) begin
               if (r_idle_cnt == IDLE_LAST) begin
                  // Latch the word here so mid-frame input changes are ignored.
                  w_idle_cnt = '0;
                  w_bit_cnt  = '0;
                  w_din      = w_frame[FRAME_BITS-1];
                  w_shift    = w_frame[FRAME_BITS-2:0];
                  w_sync     = 1'b0;
                  w_state    = SHIFT;
               end else begin
                  w_idle_cnt = r_idle_cnt + IW'(1);
               end
            end else begin
               w_idle_cnt = r_idle_cnt;
            end
         end
         SHIFT: begin
            if (w_tick) begin
               if (r_sclk) begin
                  // Falling edge: the DAC samples dac_din here.
                  w_sclk = 1'b0;
               end else begin
                  // Rising edge: the only place dac_din is allowed to move.
                  w_sclk = 1'b1;
                  if (r_bit_cnt == BIT_LAST) begin
                     w_sync  = 1'b1;
                     w_din   = 1'b0;
                     w_state = IDLE;
                  end else begin
                     w_bit_cnt = r_bit_cnt + BW'(1);
                     w_din     = r_shift[FRAME_BITS-2];
                     w_shift   = {r_shift[FRAME_BITS-3:0], 1'b0};
                  end
               end
            end else begin
               w_sclk = r_sclk;
            end
         end
         default: begin
            w_state    = IDLE;
            w_idle_cnt = '0;
            w_sclk     = 1'b1;
            w_sync     = 1'b1;
            w_din      = 1'b0;
         end
      endcase
   end

   assign dac.sclk    = r_sclk;
   assign dac.sync    = r_sync;
   assign dac.dac_din = r_din;

endmodule

// File: tb/tb_dac_spi_top.sv
// -----------------------------------------------------------------------------
// tb_dac_spi_top
// Directed bench: one DUT with default parameters (A) and one with
// DIV_HALF=1, IDLE_SCLKS=1 (B). Frames are decoded by sampling dac_din on
// falling sclk edges while sync is low.
// -----------------------------------------------------------------------------
module tb_dac_spi_top;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tb_data;
   logic [1:0] tb_sel;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   dac_spi_if if_a ();
   dac_spi_if if_b ();

   assign if_a.serial_data = tb_data;
   assign if_a.select_flag = tb_sel;
   assign if_b.serial_data = tb_data;
   assign if_b.select_flag = tb_sel;

   dac_spi_top #(.DIV_HALF(2), .IDLE_SCLKS(2)) u_dut_a (
      .clk_in (clk),
      .rst    (rst),
      .dac    (if_a)
   );

   dac_spi_top #(.DIV_HALF(1), .IDLE_SCLKS(1)) u_dut_b (
      .clk_in (clk),
      .rst    (rst),
      .dac    (if_b)
   );

   always #5 clk = ~clk;

   // Free-running cycle count for period measurements.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic get_sclk(input bit s);
      return s ? if_b.sclk : if_a.sclk;
   endfunction

   function automatic logic get_sync(input bit s);
      return s ? if_b.sync : if_a.sync;
   endfunction

   function automatic logic get_din(input bit s);
      return s ? if_b.dac_din : if_a.dac_din;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Decode one frame from DUT s. Optionally changes tb_data after chg_fall
   // falling edges to show that the frame in flight is unaffected.
   task automatic capture(input bit s, input bit wait_high, input int chg_fall,
                          input logic [7:0] chg_val,
                          output logic [15:0] word, output int falls,
                          output int glitches, output int t_start,
                          output int sclk_per, output bit timeout);
      int   guard;
      int   first_fall;
      logic p_sclk;
      logic p_din;
      word = '0; falls = 0; glitches = 0; sclk_per = 0; timeout = 1'b0;
      first_fall = 0; guard = 0;
      if (wait_high) begin
         while (get_sync(s) !== 1'b1 && guard < 500) begin
            @(negedge clk); guard++;
         end
      end
      while (get_sync(s) !== 1'b0 && guard < 500) begin
         @(negedge clk); guard++;
      end
      t_start = cyc;
      p_sclk = get_sclk(s);
      p_din  = get_din(s);
      while (get_sync(s) === 1'b0 && guard < 500) begin
         @(negedge clk); guard++;
         if (p_sclk === 1'b1 && get_sclk(s) === 1'b0) begin
            if (get_din(s) !== p_din) glitches++;
            word = {word[14:0], p_din};
            falls++;
            if (falls == 1) first_fall = cyc;
            else if (falls == 2) sclk_per = cyc - first_fall;
            if (falls == chg_fall) tb_data = chg_val;
         end
         p_sclk = get_sclk(s);
         p_din  = get_din(s);
      end
      if (guard >= 500) timeout = 1'b1;
   endtask

   initial begin
      logic [15:0] w;
      int          f, g, t1, t2, sp, n, guard;
      bit          to;
      logic        p_sclk;

      // Reset values
      rst = 1'b1; tb_data = 8'd185; tb_sel = 2'b10;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_sclk_a", 32'(if_a.sclk), 32'd1);
      chk("rst_sync_a", 32'(if_a.sync), 32'd1);
      chk("rst_din_a",  32'(if_a.dac_din), 32'd0);
      chk("rst_pins_b", {29'd0, if_b.sclk, if_b.sync, if_b.dac_din}, 32'b110);

      // Idle interval after reset release: 8 clk_in cycles
      rst = 1'b0;
      n = 0;
      while (if_a.sync !== 1'b0 && n < 100) begin
         @(negedge clk); n++;
      end
      chk("idle_after_rst", 32'(n), 32'd8);

      // Frame 1: code changes to 92 mid-frame, content must stay 0x8B90
      capture(1'b0, 1'b0, 8, 8'd92, w, f, g, t1, sp, to);
      chk("f1_timeout", 32'(to), 32'd0);
      chk("f1_word", 32'(w), 32'h8B90);
      chk("f1_falls", 32'(f), 32'd16);
      chk("f1_glitch", 32'(g), 32'd0);
      chk("sclk_period_a", 32'(sp), 32'd4);

      // Frame 2 picks up the new code; frame period 72
      capture(1'b0, 1'b0, 0, 8'd0, w, f, g, t2, sp, to);
      chk("f2_timeout", 32'(to), 32'd0);
      chk("f2_word", 32'(w), 32'h85C0);
      chk("f2_falls", 32'(f), 32'd16);
      chk("f2_glitch", 32'(g), 32'd0);
      chk("frame_period_a", 32'(t2 - t1), 32'd72);

      // Reset after bit 7 of a frame
      guard = 0;
      while (if_a.sync !== 1'b1 && guard < 500) begin @(negedge clk); guard++; end
      while (if_a.sync !== 1'b0 && guard < 500) begin @(negedge clk); guard++; end
      n = 0;
      p_sclk = if_a.sclk;
      while (n < 8 && guard < 500) begin
         @(negedge clk); guard++;
         if (p_sclk === 1'b1 && if_a.sclk === 1'b0) n++;
         p_sclk = if_a.sclk;
      end
      chk("midrst_reach", 32'(guard < 500), 32'd1);
      rst = 1'b1; tb_sel = 2'b01;
      @(negedge clk);
      chk("midrst_pins_a", {29'd0, if_a.sclk, if_a.sync, if_a.dac_din}, 32'b110);
      rst = 1'b0;
      n = 0;
      while (if_a.sync !== 1'b0 && n < 100) begin
         @(negedge clk); n++;
      end
      chk("midrst_idle", 32'(n), 32'd8);
      capture(1'b0, 1'b0, 0, 8'd0, w, f, g, t1, sp, to);
      chk("f3_timeout", 32'(to), 32'd0);
      chk("f3_word", 32'(w), 32'h45C0);
      chk("f3_falls", 32'(f), 32'd16);

      // Parameter sweep: DIV_HALF=1, IDLE_SCLKS=1
      tb_data = 8'd185; tb_sel = 2'b10;
      capture(1'b1, 1'b1, 0, 8'd0, w, f, g, t1, sp, to);
      chk("b1_timeout", 32'(to), 32'd0);
      chk("b1_word", 32'(w), 32'h8B90);
      chk("b1_falls", 32'(f), 32'd16);
      chk("b1_glitch", 32'(g), 32'd0);
      chk("sclk_period_b", 32'(sp), 32'd2);
      capture(1'b1, 1'b0, 0, 8'd0, w, f, g, t2, sp, to);
      chk("b2_word", 32'(w), 32'h8B90);
      chk("frame_period_b", 32'(t2 - t1), 32'd34);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
